// File: rtl/mult_div_ctrl.sv
// Sequencer for MULT/DIV/DIVM: selects operands, starts the unit, waits for done under a watchdog, commits Hi/Lo.
// Accept-to-done is 3+k cycles; requests outside IDLE are dropped, and reset cancels any pending pulse.
module mult_div_ctrl #(
  parameter int TIMEOUT_CYCLES = 40
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       op_valid,
  input  logic [1:0] op_code,
  output logic       op_ready,
  input  logic       divisor_is_zero,
  input  logic       unit_done,
  output logic       MDSrcAControl,
  output logic       MDSrcBControl,
  output logic       mult_start,
  output logic       div_start,
  output logic       hilo_write,
  output logic       busy,
  output logic       done,
  output logic       div_zero_exc,
  output logic       illegal_op,
  output logic       timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_RUN,
    S_COMMIT,
    S_EXC
  } state_t;

  typedef enum logic [1:0] {
    C_NONE,
    C_DZERO,
    C_ILLEGAL,
    C_TIMEOUT
  } cause_t;

  localparam logic [1:0] OP_MULT    = 2'b00;
  localparam logic [1:0] OP_DIVM    = 2'b10;
  localparam logic [1:0] OP_ILLEGAL = 2'b11;

  localparam int CW = 6;
  localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);

  state_t        state, state_nxt;
  cause_t        cause, cause_nxt;
  logic [1:0]    op_q;
  logic [CW-1:0] count;
  logic          mux_a, mux_b;
  logic          live;
  logic          first_run;

  assign first_run = (state == S_RUN) && (count == '0);

  always_comb begin
    state_nxt = state;
    cause_nxt = cause;
    unique case (state)
      S_IDLE: begin
        if (op_valid) begin
          if (op_code == OP_ILLEGAL) begin
            state_nxt = S_EXC;
            cause_nxt = C_ILLEGAL;
          end else begin
            state_nxt = S_SELECT;
          end
        end
      end
      S_SELECT: begin
        // The zero-divisor flag is only meaningful for the divide ops.
        if ((op_q != OP_MULT) && divisor_is_zero) begin
          state_nxt = S_EXC;
          cause_nxt = C_DZERO;
        end else begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        // unit_done takes priority over the watchdog on the last count.
        if (!first_run && unit_done) begin
          state_nxt = S_COMMIT;
        end else if (count == LAST_COUNT) begin
          state_nxt = S_EXC;
          cause_nxt = C_TIMEOUT;
        end
      end
      S_COMMIT: state_nxt = S_IDLE;
      S_EXC:    state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cause <= C_NONE;
      op_q  <= OP_MULT;
      count <= '0;
      mux_a <= 1'b0;
      mux_b <= 1'b0;
    end else begin
      state <= state_nxt;
      cause <= cause_nxt;
      if ((state == S_IDLE) && op_valid) begin
        op_q <= op_code;
      end
      if (state == S_SELECT) begin
        count <= '0;
      end else if (state == S_RUN) begin
        count <= count + 1'b1;
      end
      if (state_nxt == S_SELECT) begin
        mux_a <= (op_code == OP_DIVM);
        mux_b <= (op_code == OP_DIVM);
      end else if ((state_nxt == S_IDLE) || (state_nxt == S_EXC)) begin
        mux_a <= 1'b0;
        mux_b <= 1'b0;
      end
    end
  end

  assign live          = !reset;
  assign op_ready      = (state == S_IDLE) && live;
  assign busy          = (state != S_IDLE);
  assign MDSrcAControl = mux_a;
  assign MDSrcBControl = mux_b;
  assign mult_start    = live && first_run && (op_q == OP_MULT);
  assign div_start     = live && first_run && (op_q != OP_MULT);
  assign hilo_write    = live && (state == S_COMMIT);
  assign done          = live && (state == S_COMMIT);
  assign div_zero_exc  = live && (state == S_EXC) && (cause == C_DZERO);
  assign illegal_op    = live && (state == S_EXC) && (cause == C_ILLEGAL);
  assign timeout_err   = live && (state == S_EXC) && (cause == C_TIMEOUT);

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(mult_start && div_start));
      assert (!hilo_write || done);
    end
  end

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Randomised scoreboard bench for mult_div_ctrl: expected pulses are queued per op and matched by a monitor.
module tb_mult_div_ctrl;
  localparam int T = 40;

  logic       clk = 1'b0;
  logic       reset;
  logic       op_valid;
  logic [1:0] op_code;
  logic       op_ready;
  logic       divisor_is_zero;
  logic       unit_done;
  logic       MDSrcAControl, MDSrcBControl;
  logic       mult_start, div_start, hilo_write, busy, done;
  logic       div_zero_exc, illegal_op, timeout_err;

  mult_div_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code), .op_ready(op_ready),
    .divisor_is_zero(divisor_is_zero), .unit_done(unit_done),
    .MDSrcAControl(MDSrcAControl), .MDSrcBControl(MDSrcBControl),
    .mult_start(mult_start), .div_start(div_start), .hilo_write(hilo_write), .busy(busy),
    .done(done), .div_zero_exc(div_zero_exc), .illegal_op(illegal_op), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // {mult_start, div_start, hilo_write, done, dz, illegal, timeout, muxA, muxB}
  localparam logic [8:0] E_MST = 9'h100;
  localparam logic [8:0] E_DST = 9'h080;
  localparam logic [8:0] E_CMT = 9'h060;
  localparam logic [8:0] E_DZ  = 9'h010;
  localparam logic [8:0] E_ILL = 9'h008;
  localparam logic [8:0] E_TO  = 9'h004;

  typedef struct {
    int         cyc;
    logic [8:0] v;
  } ev_t;
  ev_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic push_ev(input int c, input logic [8:0] v);
    ev_t e;
    e.cyc = c;
    e.v   = v;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    logic [8:0] v;
    ev_t e;
    v = {mult_start, div_start, hilo_write, done, div_zero_exc, illegal_op, timeout_err,
         MDSrcAControl, MDSrcBControl};
    if (v[8:2] != 7'd0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event", {23'd0, v}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("event_outputs", {23'd0, v}, {23'd0, e.v});
        chk("event_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (!op_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!op_ready) chk("op_ready_wait", {31'd0, op_ready}, 32'd1);
  endtask

  // k = cycles from start pulse to unit_done; k==0 means unit_done never comes.
  task automatic run_op(input logic [1:0] opc, input bit dz, input int k, input bit noise);
    int a;
    logic [8:0] m;
    bit is_mul, runs;
    a      = cyc + 1;
    m      = (opc == 2'b10) ? 9'h003 : 9'h000;
    is_mul = (opc == 2'b00);
    runs   = (opc != 2'b11) && !(dz && !is_mul);
    if (opc == 2'b11) begin
      push_ev(a, E_ILL);
    end else if (!runs) begin
      push_ev(a + 1, E_DZ);
    end else begin
      push_ev(a + 1, (is_mul ? E_MST : E_DST) | m);
      if (k == 0) push_ev(a + T + 1, E_TO);
      else        push_ev(a + 2 + k, E_CMT | m);
    end
    op_valid = 1'b1;
    op_code = opc;
    divisor_is_zero = dz;
    @(negedge clk);
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    chk("ready_after_accept", {31'd0, op_ready}, 32'd0);
    unit_done = 1'b0;
    op_valid = noise;
    op_code = 2'b11;
    @(negedge clk);
    op_valid = 1'b0;
    if (opc == 2'b11) chk("illegal_busy_one_cycle", {31'd0, busy}, 32'd0);
    if (runs) begin
      unit_done = (k == 1) || noise;
      for (int c = a + 2; c <= a + 1 + k; c++) begin
        @(negedge clk);
        unit_done = (c == a + 1 + k);
      end
      @(negedge clk);
      unit_done = 1'b0;
    end
    wait_ready();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int a;
    reset = 1'b1;
    op_valid = 1'b0;
    op_code = 2'b00;
    divisor_is_zero = 1'b0;
    unit_done = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_op_ready_low", {31'd0, op_ready}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_op_ready", {31'd0, op_ready}, 32'd1);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_outputs", {21'd0, mult_start, div_start, hilo_write, done, div_zero_exc,
        illegal_op, timeout_err, MDSrcAControl, MDSrcBControl, 1'b0, 1'b0, 1'b0}, 32'd0);

    run_op(2'b00, 1'b0, 32, 1'b0);
    run_op(2'b10, 1'b0, 1, 1'b0);
    run_op(2'b01, 1'b1, 1, 1'b0);
    run_op(2'b11, 1'b0, 1, 1'b0);
    run_op(2'b00, 1'b0, 0, 1'b0);
    run_op(2'b01, 1'b0, T - 1, 1'b0);
    run_op(2'b10, 1'b0, 0, 1'b1);
    run_op(2'b00, 1'b1, 5, 1'b1);

    // Reset during RUN, stray unit_done afterwards, then a fresh MULT.
    a = cyc + 1;
    push_ev(a + 1, E_MST);
    op_valid = 1'b1;
    op_code = 2'b00;
    divisor_is_zero = 1'b0;
    @(negedge clk);
    op_valid = 1'b0;
    while (cyc < a + 9) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_reset_op_ready_low", {31'd0, op_ready}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_reset_ready", {31'd0, op_ready}, 32'd1);
    chk("post_reset_busy", {31'd0, busy}, 32'd0);
    chk("post_reset_mux", {30'd0, MDSrcAControl, MDSrcBControl}, 32'd0);
    @(negedge clk);
    unit_done = 1'b1;
    run_op(2'b00, 1'b0, 3, 1'b0);

    for (int i = 0; i < 60; i++) begin
      logic [1:0] opc;
      bit dz, nz;
      int r, k;
      opc = 2'($urandom_range(0, 3));
      dz  = ($urandom_range(0, 3) == 0);
      nz  = 1'($urandom_range(0, 1));
      r   = $urandom_range(0, 9);
      if (r == 0)      k = 0;
      else if (r == 1) k = T - 1;
      else             k = $urandom_range(1, 12);
      run_op(opc, dz, k, nz);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div_ctrl.md
Name: mult_div_ctrl

Overview:
- Sequencing controller for the multi-cycle multiply/divide operation (MULT, DIV, DIVM).
- Accepts one operation from the main control unit and drives the MDSrcA/MDSrcB operand-select lines.
- Pulses a start to the external mult or div unit, waits for its done with a watchdog, then commits Hi/Lo.
- Screens divide-by-zero and illegal opcodes before any unit starts.

Parameters:
- TIMEOUT_CYCLES, 40: maximum RUN cycles to wait for unit_done before aborting; legal range 2..63.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- op_valid  input  1  operation request from the main control unit.
- op_code  input  2  00=MULT, 01=DIV, 10=DIVM, 11=illegal.
- op_ready  output  1  controller can accept an operation.
- divisor_is_zero  input  1  selected operand B equals 0; computed externally from the mux output.
- unit_done  input  1  active mult/div unit has a result ready.
- MDSrcAControl  output  1  0=RegA_out, 1=MDR_out.
- MDSrcBControl  output  1  0=RegB_out, 1=second memory word register.
- mult_start  output  1  one-cycle start pulse to the multiplier.
- div_start  output  1  one-cycle start pulse to the divider.
- hilo_write  output  1  load enable for Hi and Lo.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse: result committed.
- div_zero_exc  output  1  one-cycle pulse: divide by zero.
- illegal_op  output  1  one-cycle pulse: opcode 11.
- timeout_err  output  1  one-cycle pulse: watchdog expired.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: state=IDLE, counter=0, op_ready=1 (low while reset is asserted), all other outputs 0.
- States: IDLE, SELECT, RUN, COMMIT, EXC.
- IDLE:
  - op_ready=1, busy=0.
  - op_valid=1 at an edge → latch op_code. Opcode 11 → EXC. Otherwise → SELECT.
  - op_valid while not in IDLE is ignored; no queueing.
- SELECT (1 cycle):
  - busy=1; mux controls driven from the latched op.
    - MULT and DIV: A=0, B=0.
    - DIVM: A=1, B=1.
  - Mux controls are registered and held constant from SELECT through COMMIT. They are 0 in IDLE and EXC.
  - divisor_is_zero is sampled only in SELECT and only for DIV/DIVM.
    - If 1 → EXC. No start pulse; Hi/Lo untouched.
    - Otherwise → RUN.
- RUN:
  - First RUN cycle: mult_start (MULT) or div_start (DIV/DIVM) = 1. Exactly one pulse per operation.
  - The counter clears on RUN entry and increments each RUN cycle.
  - unit_done is ignored during the start-pulse cycle.
  - unit_done=1 in a later cycle → COMMIT.
  - Counter reaches TIMEOUT_CYCLES-1 with unit_done=0 → EXC (timeout).
  - If unit_done and the last count coincide, unit_done wins → COMMIT.
- COMMIT (1 cycle): hilo_write=1 and done=1 together → IDLE.
- EXC (1 cycle):
  - Exactly one of div_zero_exc, illegal_op or timeout_err = 1, matching the cause.
  - hilo_write=0 → IDLE.
- busy=1 in SELECT, RUN, COMMIT and EXC.
- op_ready = (state==IDLE) && !reset.
- Latency:
  - Accept edge to done pulse = 3 + k cycles, where unit_done arrives k cycles after the start cycle (k≥1).
  - Back-to-back operations: the next op is accepted on the edge the controller returns to IDLE. Minimum spacing is one IDLE cycle.
- Reset mid-operation: the next edge forces IDLE.
  - Any pending start, hilo_write or pulse is cancelled; no pulse is generated by the reset.
  - unit_done arriving after reset is ignored in IDLE.
- Invariant: at most one of mult_start and div_start is asserted in any cycle.
- Invariant: hilo_write never asserts without done.

Test Plan:
- MULT, unit_done 32 cycles after mult_start:
  - mult_start single pulse at cycle 2.
  - MDSrcA=0 and MDSrcB=0 throughout.
  - hilo_write and done at cycle 35; op_ready=1 at cycle 36.
- DIVM with divisor_is_zero=0, unit_done at k=1:
  - MDSrcA=1 and MDSrcB=1 from SELECT through COMMIT.
  - div_start at cycle 2; done at cycle 4.
- DIV with divisor_is_zero=1 in SELECT:
  - div_zero_exc pulse at cycle 2.
  - No div_start, no hilo_write; op_ready at cycle 3.
- op_code=11 → illegal_op pulse at cycle 1, busy=1 for that cycle only, no starts.
- TIMEOUT_CYCLES=40, unit_done held 0: timeout_err at cycle 42, no hilo_write. Repeat with unit_done on the last RUN count → COMMIT, no timeout_err.
- Reset in RUN at cycle 10, then unit_done=1 at cycle 12:
  - IDLE at cycle 11, no done or hilo_write.
  - Second MULT issued at cycle 12 completes normally.
